// File: rtl/tetris_pkg.sv
// Shared definitions for the falling-piece game blocks: board geometry,
// piece type encoding, controller state encoding and the type-mapping helper.
package tetris_pkg;

  localparam int COLS      = 10;
  localparam int ROWS      = 20;
  localparam int NUM_TYPES = 7;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    T_I = 3'd0,
    T_O = 3'd1,
    T_T = 3'd2,
    T_S = 3'd3,
    T_Z = 3'd4,
    T_J = 3'd5,
    T_L = 3'd6
  } piece_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPAWN,
    ST_CHECK,
    ST_FALL,
    ST_LOCK,
    ST_WAIT,
    ST_OVER
  } state_t;

  // Fold the 8 raw LFSR codes onto the 7 piece types; the unused code 7 becomes type 0.
  function automatic logic [2:0] map_type(input logic [2:0] raw);
    return (raw == 3'(NUM_TYPES)) ? 3'(T_I) : raw;
  endfunction

endpackage

// File: rtl/piece_lfsr.sv
// Free-running 16-bit Galois LFSR producing a candidate piece type every cycle.
module piece_lfsr
  import tetris_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] type_out
);

  logic [15:0] lfsr;

  // Shift right every cycle; feedback bit lfsr[0] is folded back through the tap mask.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
  end

  assign type_out = map_type(lfsr[2:0]);

endmodule

// File: rtl/piece_ctrl.sv
// Falling-piece controller: owns the active piece position/orientation, applies
// button and gravity moves gated by the board's permission flags, commits the
// piece with a one-cycle refresh pulse and spawns the next one.
// The piece type output is named piece_type because 'type' is a reserved word.
module piece_ctrl
  import tetris_pkg::*;
#(
  parameter int          SPAWN_X   = 3,
  parameter int          SPAWN_Y   = 0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          WAIT_MIN  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        btn_l,
  input  logic        btn_r,
  input  logic        btn_rot,
  input  logic        btn_dn,
  input  logic        tick,
  input  logic        el,
  input  logic        er,
  input  logic        eu,
  input  logic        edrop,
  input  logic        overflow,
  input  logic        refresh_done,
  output logic [4:0]  x,
  output logic [4:0]  y,
  output logic [2:0]  piece_type,
  output logic [1:0]  dir,
  output logic [2:0]  next_type,
  output logic        refresh,
  output logic        game_over,
  output logic [15:0] piece_cnt
);

  localparam int          WCW       = $clog2(WAIT_MIN + 1) + 1;
  localparam logic [2:0]  SEED_TYPE = map_type(LFSR_SEED[2:0]);

  state_t           state;
  logic [WCW-1:0]   wait_cnt;
  logic [2:0]       cand_type;

  piece_lfsr #(.LFSR_SEED(LFSR_SEED)) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .type_out (cand_type)
  );

  // Controller FSM with all outputs registered; refresh defaults low so it
  // is a single-cycle pulse coinciding with the LOCK state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      x          <= 5'(SPAWN_X);
      y          <= 5'(SPAWN_Y);
      dir        <= 2'd0;
      piece_type <= 3'(T_I);
      next_type  <= SEED_TYPE;
      refresh    <= 1'b0;
      game_over  <= 1'b0;
      piece_cnt  <= 16'd0;
      wait_cnt   <= '0;
    end else begin
      refresh <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) state <= ST_SPAWN;
        end

        ST_SPAWN: begin
          x          <= 5'(SPAWN_X);
          y          <= 5'(SPAWN_Y);
          dir        <= 2'd0;
          piece_type <= next_type;
          next_type  <= cand_type;
          state      <= ST_CHECK;
        end

        // Permission/overflow inputs now describe the freshly spawned piece.
        ST_CHECK: begin
          if (overflow) begin
            state     <= ST_OVER;
            game_over <= 1'b1;
          end else begin
            state <= ST_FALL;
          end
        end

        // One action per cycle; gravity and soft drop outrank player moves.
        ST_FALL: begin
          if (tick || btn_dn) begin
            if (edrop) begin
              y <= y + 5'd1;
            end else begin
              state   <= ST_LOCK;
              refresh <= 1'b1;
            end
          end else if (btn_rot && eu) begin
            dir <= dir + 2'd1;
          end else if (btn_l && el) begin
            x <= x - 5'd1;
          end else if (btn_r && er) begin
            x <= x + 5'd1;
          end
        end

        ST_LOCK: begin
          piece_cnt <= piece_cnt + 16'd1;
          wait_cnt  <= WCW'(1);
          state     <= ST_WAIT;
        end

        // The board needs WAIT_MIN cycles before its idle flag is trustworthy.
        ST_WAIT: begin
          if ((wait_cnt >= WCW'(WAIT_MIN)) && refresh_done) begin
            state <= ST_SPAWN;
          end else if (wait_cnt < WCW'(WAIT_MIN)) begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end

        ST_OVER: begin
          if (start) begin
            piece_cnt <= 16'd0;
            game_over <= 1'b0;
            state     <= ST_SPAWN;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piece_ctrl.sv
// Directed bench for piece_ctrl: expectations are queued when stimulus is
// driven and popped against DUT outputs after the relevant clock edge.
module tb_piece_ctrl;

  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst, start, btn_l, btn_r, btn_rot, btn_dn, tick;
  logic        el, er, eu, edrop, overflow, refresh_done;
  logic [4:0]  x, y;
  logic [2:0]  piece_type, next_type;
  logic [1:0]  dir;
  logic        refresh, game_over;
  logic [15:0] piece_cnt;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          total_cnt = 0;
  int          pass_cnt  = 0;
  int          fail_cnt  = 0;
  logic [15:0] m_lfsr;
  logic [2:0]  exp_type, exp_next;

  always #5 clk = ~clk;

  piece_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .btn_l        (btn_l),
    .btn_r        (btn_r),
    .btn_rot      (btn_rot),
    .btn_dn       (btn_dn),
    .tick         (tick),
    .el           (el),
    .er           (er),
    .eu           (eu),
    .edrop        (edrop),
    .overflow     (overflow),
    .refresh_done (refresh_done),
    .x            (x),
    .y            (y),
    .piece_type   (piece_type),
    .dir          (dir),
    .next_type    (next_type),
    .refresh      (refresh),
    .game_over    (game_over),
    .piece_cnt    (piece_cnt)
  );

  // Reference generator: x^16+x^14+x^13+x^11+1 Galois LFSR, stepping every non-reset cycle.
  always @(posedge clk) begin
    if (rst) m_lfsr <= SEED;
    else     m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  function automatic logic [2:0] ref_map(input logic [2:0] raw);
    return (raw == 3'd7) ? 3'd0 : raw;
  endfunction

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop(input logic [31:0] obs);
    exp_t e;
    logic ok;
    total_cnt++;
    if (sb.size() == 0) begin
      fail_cnt++;
      $display("FAIL scoreboard_empty: observed %0h with no expectation", obs);
    end else begin
      e  = sb.pop_front();
      ok = (obs === e.val);
      if (ok) pass_cnt++;
      assert (ok) else begin
        fail_cnt++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic push_piece(input logic [4:0] ex, input logic [4:0] ey, input logic [1:0] ed,
                            input logic [2:0] et, input logic [2:0] en);
    push("x", 32'(ex));
    push("y", 32'(ey));
    push("dir", 32'(ed));
    push("type", 32'(et));
    push("next_type", 32'(en));
  endtask

  task automatic pop_piece();
    pop(32'(x));
    pop(32'(y));
    pop(32'(dir));
    pop(32'(piece_type));
    pop(32'(next_type));
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; btn_l = 1'b0; btn_r = 1'b0; btn_rot = 1'b0; btn_dn = 1'b0;
    tick = 1'b0; el = 1'b0; er = 1'b0; eu = 1'b0; edrop = 1'b0; overflow = 1'b0;
    refresh_done = 1'b1;
    repeat (3) step();

    // Reset state
    push_piece(5'd3, 5'd0, 2'd0, 3'd0, ref_map(SEED[2:0]));
    push("refresh_rst", 0); push("game_over_rst", 0); push("piece_cnt_rst", 0);
    pop_piece(); pop(32'(refresh)); pop(32'(game_over)); pop(32'(piece_cnt));
    rst = 1'b0;

    // Start: IDLE -> SPAWN -> CHECK -> FALL
    start = 1'b1;
    step();                                   // SPAWN
    start    = 1'b0;
    exp_type = ref_map(SEED[2:0]);
    exp_next = ref_map(m_lfsr[2:0]);
    push_piece(5'd3, 5'd0, 2'd0, exp_type, exp_next);
    step();                                   // CHECK
    pop_piece();
    step();                                   // FALL
    push("game_over_fall", 0); pop(32'(game_over));

    // Left moves down to column 0, then a blocked one
    el = 1'b1;
    for (int i = 0; i < 3; i++) begin
      btn_l = 1'b1; push("x_left", 32'(2 - i)); step(); btn_l = 1'b0; pop(32'(x));
    end
    el = 1'b0;
    btn_l = 1'b1; push("x_left_blocked", 0); step(); btn_l = 1'b0; pop(32'(x));

    // Rotation wraps 3 -> 0, blocked rotation is a no-op
    eu = 1'b1;
    for (int i = 0; i < 4; i++) begin
      btn_rot = 1'b1; push("dir_rot", 32'((i + 1) % 4)); step(); btn_rot = 1'b0; pop(32'(dir));
    end
    eu = 1'b0;
    btn_rot = 1'b1; push("dir_rot_blocked", 0); step(); btn_rot = 1'b0; pop(32'(dir));

    // Gravity outranks a simultaneous right move
    edrop = 1'b1; er = 1'b1; tick = 1'b1; btn_r = 1'b1;
    push("y_tick", 1); push("x_dropped_right", 0);
    step();
    tick = 1'b0; btn_r = 1'b0;
    pop(32'(y)); pop(32'(x));

    // Blocked gravity locks the piece; refresh_done held high throughout
    edrop = 1'b0; tick = 1'b1;
    push("refresh_lock", 1); push("piece_cnt_lock", 0);
    step();                                   // LOCK
    tick = 1'b0;
    pop(32'(refresh)); pop(32'(piece_cnt));
    btn_r = 1'b1; er = 1'b1;
    push("refresh_wait1", 0); push("piece_cnt_wait1", 1); push("x_wait1", 0); push("y_wait1", 1);
    step();                                   // WAIT 1
    btn_r = 1'b0;
    pop(32'(refresh)); pop(32'(piece_cnt)); pop(32'(x)); pop(32'(y));
    tick = 1'b1; edrop = 1'b1;
    push("y_wait2", 1); push("x_wait2", 0);
    step();                                   // WAIT 2
    tick = 1'b0; edrop = 1'b0;
    pop(32'(y)); pop(32'(x));
    push("y_spawn_cycle", 1);
    step();                                   // SPAWN
    pop(32'(y));
    exp_type = exp_next;
    exp_next = ref_map(m_lfsr[2:0]);
    overflow = 1'b1;
    push_piece(5'd3, 5'd0, 2'd0, exp_type, exp_next);
    push("game_over_check", 0);
    step();                                   // CHECK
    pop_piece(); pop(32'(game_over));

    // Overflow at spawn: game over, moves ignored
    push("game_over_over", 1); push("refresh_over", 0);
    step();                                   // OVER
    pop(32'(game_over)); pop(32'(refresh));
    el = 1'b1; eu = 1'b1; edrop = 1'b1; btn_l = 1'b1; btn_rot = 1'b1; tick = 1'b1;
    push("x_over", 3); push("y_over", 0); push("dir_over", 0); push("game_over_hold", 1);
    step();
    btn_l = 1'b0; btn_rot = 1'b0; tick = 1'b0;
    pop(32'(x)); pop(32'(y)); pop(32'(dir)); pop(32'(game_over));

    // Restart from OVER clears the counter and spawns the queued type
    overflow = 1'b0; start = 1'b1;
    push("piece_cnt_restart", 0); push("game_over_restart", 0);
    step();                                   // SPAWN
    start = 1'b0;
    pop(32'(piece_cnt)); pop(32'(game_over));
    exp_type = exp_next;
    exp_next = ref_map(m_lfsr[2:0]);
    push_piece(5'd3, 5'd0, 2'd0, exp_type, exp_next);
    step();                                   // CHECK
    pop_piece();
    step();                                   // FALL

    // Soft drop moves, then locks; reset lands mid-WAIT
    edrop = 1'b1; btn_dn = 1'b1; push("y_soft_drop", 1); step(); btn_dn = 1'b0; pop(32'(y));
    edrop = 1'b0; refresh_done = 1'b0; btn_dn = 1'b1;
    push("refresh_lock2", 1);
    step();                                   // LOCK
    btn_dn = 1'b0;
    pop(32'(refresh));
    push("piece_cnt_wait", 1);
    step();                                   // WAIT 1
    pop(32'(piece_cnt));
    rst = 1'b1;
    push_piece(5'd3, 5'd0, 2'd0, 3'd0, ref_map(SEED[2:0]));
    push("refresh_after_rst", 0); push("piece_cnt_after_rst", 0); push("game_over_after_rst", 0);
    step();
    rst = 1'b0;
    pop_piece(); pop(32'(refresh)); pop(32'(piece_cnt)); pop(32'(game_over));

    // IDLE ignores moves and does not spawn without start
    el = 1'b1; btn_l = 1'b1; refresh_done = 1'b1;
    push("x_idle", 3); push("type_idle", 0);
    step();
    btn_l = 1'b0;
    step();
    pop(32'(x)); pop(32'(piece_type));

    if (sb.size() != 0) begin
      total_cnt++;
      fail_cnt++;
      $display("FAIL scoreboard_leftover: %0d expectations never checked", sb.size());
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/piece_ctrl.md
Name: piece_ctrl

Overview:
- Falling-piece controller that sits directly upstream of the board store.
- Owns the active piece state (x, y, type, dir) and turns debounced button pulses plus the gravity tick into moves. Each move is gated by the board's combinational permission flags (el, er, eu, edrop, overflow).
- When a piece can no longer fall, it issues the refresh pulse that commits the piece to the board. It then waits for the board to finish, and spawns the next piece from a pseudo-random generator.

Parameters:
- SPAWN_X, 3, column of piece origin at spawn (0..9)
- SPAWN_Y, 0, row of piece origin at spawn (0..19)
- LFSR_SEED, 16'hACE1, nonzero reset value of type generator
- WAIT_MIN, 2, cycles after refresh before refresh_done is sampled

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse; begins a game from IDLE or OVER
- btn_l  in  1  one-cycle pulse, move left
- btn_r  in  1  one-cycle pulse, move right
- btn_rot  in  1  one-cycle pulse, rotate
- btn_dn  in  1  one-cycle pulse, soft drop
- tick  in  1  one-cycle gravity pulse
- el, er, eu, edrop  in  1 each  board permission: left / right / rotate / drop legal for current piece
- overflow  in  1  1 = current piece cells collide with the board
- refresh_done  in  1  board idle, commit finished
- x  out  5  piece origin column
- y  out  5  piece origin row
- type  out  3  piece type 0..6
- dir  out  2  rotation 0..3
- next_type  out  3  preview of following piece
- refresh  out  1  one-cycle commit pulse to board
- game_over  out  1  level, high in OVER
- piece_cnt  out  16  pieces locked since start

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - State IDLE; x=SPAWN_X, y=SPAWN_Y, dir=0, type=0.
  - next_type is taken from the seed.
  - refresh=0, game_over=0, piece_cnt=0, LFSR=LFSR_SEED.
- Reset asserted in any state, including WAIT mid-commit, returns to IDLE next edge. Board resync is the board's own concern.
- LFSR:
  - 16-bit Galois, taps 16,14,13,11.
  - Advances every cycle except during reset.
  - Candidate type = lfsr[2:0], with 3'b111 mapped to 3'b000.
- States:
  - IDLE: on start go to SPAWN.
  - SPAWN (1 cycle):
    - Load x=SPAWN_X, y=SPAWN_Y, dir=0, type=next_type.
    - Load next_type = candidate.
    - Go to CHECK.
  - CHECK (1 cycle; permission inputs now reflect the new piece): overflow=1 goes to OVER, else FALL.
  - FALL: at most one action per cycle, in this priority:
    1. tick or btn_dn:
       - if edrop, y<=y+1;
       - else go to LOCK (y unchanged).
    2. btn_rot with eu: dir<=dir+1, wrapping 3 to 0.
    3. btn_l with el: x<=x-1.
    4. btn_r with er: x<=x+1.
  - Lower-priority pulses in the same cycle are dropped, not queued.
  - A move whose permission is 0 is a no-op.
  - x, y and dir never change outside SPAWN/FALL.
  - LOCK (1 cycle): refresh=1, piece_cnt<=piece_cnt+1 (wraps at 16'hFFFF), go to WAIT.
  - WAIT:
    - Ignore refresh_done for the first WAIT_MIN cycles.
    - Afterwards, refresh_done=1 goes to SPAWN.
    - Buttons and tick are ignored throughout.
  - OVER: game_over=1; outputs hold; start goes to SPAWN with piece_cnt<=0.
- refresh is high only in LOCK, for exactly one cycle per lock.
- Latency:
  - A legal move is visible on x/y/dir 1 cycle after the pulse.
  - Lock to new piece takes a minimum of 1 (LOCK) + WAIT_MIN + 1 (SPAWN) + 1 (CHECK) cycles.
- start during FALL/WAIT is ignored.

Decomposition:
- Shared package tetris_pkg holds:
  - board constants COLS=10, ROWS=20;
  - piece type encoding 0..6 and NUM_TYPES=7;
  - the state enum for this block.
- Sub-module piece_lfsr holds the LFSR plus the 7-type mapping, with ports clk, rst, type_out.

Test Plan:
- Reset then start with overflow=0 → x=3, y=0, dir=0 by the cycle after CHECK; state FALL; game_over=0.
- In FALL, btn_l with el=1 three times → x=0; a fourth btn_l with el=0 → x stays 0.
- btn_rot with eu=1 four times → dir sequence 1,2,3,0; btn_rot with eu=0 → dir unchanged.
- tick and btn_r in the same cycle, edrop=1, er=1 → y+1, x unchanged.
- tick with edrop=0 → refresh high exactly 1 cycle, piece_cnt=1.
  - Holding refresh_done=1 continuously → spawn no earlier than 2 cycles after refresh.
  - The new type equals the previous next_type.
- Spawn with overflow=1 → game_over=1 and no further moves.
  - start → piece_cnt=0 and a new piece spawned.
  - rst asserted during WAIT → IDLE, refresh=0 on the next edge.
